fir_stream_ctrl: RTL and testbench

- Frame sequencer between the AXI-stream sample source and the FIR datapath.
- On `start`, admits exactly FRAME_LEN samples from the source and forwards them through a one-deep registered slice.
- Then injects NTAPS-1 zero samples to flush the filter delay line and marks the final beat with `m_tlast`.
- Signals completion with a one-cycle `done` pulse; software/testbench level sees `busy` and a progress counter.

---
 rtl/fir_pkg.sv | 15 +
 rtl/axis_reg_slice.sv | 40 ++++
 rtl/fir_stream_ctrl.sv | 135 +++++++++++++
 tb/tb_fir_stream_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Definitions shared by the FIR frame controller, the FIR core and the data source.
package fir_pkg;

    localparam int DEF_DW    = 16;
    localparam int DEF_NTAPS = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep registered AXI-stream slice; the owner decides when a beat is offered.
module axis_reg_slice #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         free_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign free_o  = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset too, because downstream observes a defined zero after reset.
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (free_o) begin
            valid_q <= load_i;
            if (load_i) begin
                data_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/fir_stream_ctrl.sv
// Frame sequencer: admits FRAME_LEN source samples, appends NTAPS-1 zero flush beats,
// tags the final beat with m_tlast and pulses done once it has been accepted.
module fir_stream_ctrl
    import fir_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int FRAME_LEN = 2048,
    parameter int NTAPS     = DEF_NTAPS,
    parameter int CW        = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [DW-1:0] s_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tlast,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] sample_cnt
);

    localparam logic [CW-1:0] FRAME_END = CW'(FRAME_LEN);
    localparam logic [CW-1:0] FLUSH_END = CW'(NTAPS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    logic          slice_free;
    logic          slice_load;
    logic          slice_clear;
    logic [DW:0]   slice_in;
    logic [DW:0]   slice_out;

    axis_reg_slice #(.W(DW + 1)) u_slice (
        .clk     (clk),
        .reset   (reset),
        .load_i  (slice_load),
        .clear_i (slice_clear),
        .data_i  (slice_in),
        .ready_i (m_tready),
        .free_o  (slice_free),
        .valid_o (m_tvalid),
        .data_o  (slice_out)
    );

    assign m_tdata    = slice_out[DW-1:0];
    assign m_tlast    = slice_out[DW];
    assign s_tready   = (state_q == RUN) & slice_free;
    assign busy       = (state_q == RUN) | (state_q == FLUSH);
    assign done       = (state_q == DONE);
    assign sample_cnt = sample_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        slice_load   = 1'b0;
        slice_clear  = 1'b0;
        slice_in     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RUN;
                    sample_cnt_d = '0;
                    flush_cnt_d  = '0;
                end
            end
            RUN: begin
                if (s_tvalid && s_tready) begin
                    slice_load = 1'b1;
                    slice_in   = {1'b0, s_tdata};
                    if (sample_cnt_q != FRAME_END) begin
                        sample_cnt_d = sample_cnt_q + CW'(1);
                    end
                    if (sample_cnt_q + CW'(1) == FRAME_END) begin
                        // A single-tap filter has no delay line, so the last sample closes the frame.
                        if (NTAPS == 1) begin
                            slice_in[DW] = 1'b1;
                            state_d      = DRAIN;
                        end else begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (slice_free) begin
                    slice_load  = 1'b1;
                    flush_cnt_d = flush_cnt_q + CW'(1);
                    if (flush_cnt_q + CW'(1) == FLUSH_END) begin
                        slice_in[DW] = 1'b1;
                        state_d      = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (m_tvalid && m_tready && m_tlast) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides any handshake this cycle; the sample count is left for inspection.
        if (abort && (state_q inside {RUN, FLUSH, DRAIN})) begin
            state_d      = IDLE;
            sample_cnt_d = sample_cnt_q;
            flush_cnt_d  = flush_cnt_q;
            slice_load   = 1'b0;
            slice_clear  = 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Self-checking bench: expected beats are the offered samples followed by NTAPS-1 zeros.
module tb_fir_stream_ctrl;

    localparam int DW   = 16;
    localparam int CW   = 12;
    localparam int FL_A = 4;
    localparam int NT_A = 3;
    localparam int FL_B = 2;
    localparam int NT_B = 1;

    logic          clk = 1'b0;
    logic          reset, abort, s_tvalid, m_tready;
    logic          start_a, start_b;
    logic [DW-1:0] s_tdata;
    logic          sel_b;

    logic          a_s_tready, a_m_tvalid, a_m_tlast, a_busy, a_done;
    logic [DW-1:0] a_m_tdata;
    logic [CW-1:0] a_sample_cnt;
    logic          b_s_tready, b_m_tvalid, b_m_tlast, b_busy, b_done;
    logic [DW-1:0] b_m_tdata;
    logic [CW-1:0] b_sample_cnt;

    logic          o_s_tready, o_m_tvalid, o_m_tlast, o_busy, o_done;
    logic [DW-1:0] o_m_tdata;
    logic [CW-1:0] o_sample_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_stream_ctrl #(.DW(DW), .FRAME_LEN(FL_A), .NTAPS(NT_A), .CW(CW)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort),
        .s_tvalid(s_tvalid), .s_tready(a_s_tready), .s_tdata(s_tdata),
        .m_tvalid(a_m_tvalid), .m_tready(m_tready), .m_tdata(a_m_tdata), .m_tlast(a_m_tlast),
        .busy(a_busy), .done(a_done), .sample_cnt(a_sample_cnt)
    );

    fir_stream_ctrl #(.DW(DW), .FRAME_LEN(FL_B), .NTAPS(NT_B), .CW(CW)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort),
        .s_tvalid(s_tvalid), .s_tready(b_s_tready), .s_tdata(s_tdata),
        .m_tvalid(b_m_tvalid), .m_tready(m_tready), .m_tdata(b_m_tdata), .m_tlast(b_m_tlast),
        .busy(b_busy), .done(b_done), .sample_cnt(b_sample_cnt)
    );

    always_comb begin
        o_s_tready   = sel_b ? b_s_tready   : a_s_tready;
        o_m_tvalid   = sel_b ? b_m_tvalid   : a_m_tvalid;
        o_m_tdata    = sel_b ? b_m_tdata    : a_m_tdata;
        o_m_tlast    = sel_b ? b_m_tlast    : a_m_tlast;
        o_busy       = sel_b ? b_busy       : a_busy;
        o_done       = sel_b ? b_done       : a_done;
        o_sample_cnt = sel_b ? b_sample_cnt : a_sample_cnt;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        start_a = v & ~sel_b;
        start_b = v & sel_b;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".m_tvalid"}, o_m_tvalid, 0);
        chk({tag, ".m_tdata"}, o_m_tdata, 0);
        chk({tag, ".m_tlast"}, o_m_tlast, 0);
        chk({tag, ".done"}, o_done, 0);
        chk({tag, ".sample_cnt"}, o_sample_cnt, 0);
        chk({tag, ".s_tready"}, o_s_tready, 0);
        chk({tag, ".busy"}, o_busy, 0);
    endtask

    // vmode: 0 always valid, 1 valid every 3rd cycle, 2 random
    // rmode: 0 always ready, 1 toggling, 2 random; dmode: 0 data 1,2,3..., 1 random data
    task automatic run_frame(input int vmode, input int rmode, input int dmode,
                             input bit restart, input string tag);
        int            fl, nt, total;
        logic [DW-1:0] src_q[$];
        logic [DW:0]   got[$];
        int            beat_cyc[$];
        int            n_acc, n_done, done_i, last_hs;
        bit            prev_stall;
        logic [DW-1:0] prev_data, cur;
        logic          prev_last;
        logic [DW:0]   exp_b;

        fl      = sel_b ? FL_B : FL_A;
        nt      = sel_b ? NT_B : NT_A;
        total   = fl + nt - 1;
        n_acc   = 0;
        n_done  = 0;
        done_i  = -1;
        last_hs = -1;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        cur = (dmode == 0) ? 16'd1 : 16'($urandom);
        src_q.push_back(cur);

        @(negedge clk);
        drive_start(1'b1);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        #1 chk({tag, ".busy_before"}, o_busy, 0);

        for (int i = 0; i < 300; i++) begin
            if (done_i >= 0 && i > done_i + 2) break;
            @(negedge clk);
            drive_start(restart && i == 3);
            case (vmode)
                0:       s_tvalid = 1'b1;
                1:       s_tvalid = (i % 3 == 0);
                default: s_tvalid = 1'($urandom_range(0, 1));
            endcase
            case (rmode)
                0:       m_tready = 1'b1;
                1:       m_tready = (i % 2 == 0);
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
            s_tdata = cur;
            #1;
            if (i == 0) chk({tag, ".busy_run"}, o_busy, 1);
            if (prev_stall) begin
                chk({tag, ".hold_valid"}, o_m_tvalid, 1);
                chk({tag, ".hold_data"}, o_m_tdata, prev_data);
                chk({tag, ".hold_last"}, o_m_tlast, prev_last);
            end
            if (o_m_tvalid && !m_tready) chk({tag, ".s_tready_stall"}, o_s_tready, 0);
            if (s_tvalid && o_s_tready) begin
                n_acc++;
                cur = (dmode == 0) ? cur + 16'd1 : 16'($urandom);
                src_q.push_back(cur);
            end
            if (o_m_tvalid && m_tready) begin
                got.push_back({o_m_tlast, o_m_tdata});
                beat_cyc.push_back(i);
                if (o_m_tlast) last_hs = i;
            end
            if (o_done) begin
                n_done++;
                done_i = i;
            end
            prev_stall = o_m_tvalid && !m_tready;
            prev_data  = o_m_tdata;
            prev_last  = o_m_tlast;
        end

        chk({tag, ".n_accepted"}, n_acc, fl);
        chk({tag, ".n_beats"}, got.size(), total);
        for (int k = 0; k < total && k < got.size(); k++) begin
            exp_b = {(k == total - 1), (k < fl ? src_q[k] : 16'h0)};
            chk({tag, ".beat"}, got[k], exp_b);
        end
        chk({tag, ".n_done"}, n_done, 1);
        chk({tag, ".done_after_last"}, done_i, last_hs + 1);
        chk({tag, ".sample_cnt"}, o_sample_cnt, fl);
        chk({tag, ".busy_end"}, o_busy, 0);
        if (vmode == 0 && rmode == 0 && beat_cyc.size() > 0) begin
            chk({tag, ".first_beat_cycle"}, beat_cyc[0], 1);
            chk({tag, ".beat_span"}, beat_cyc[$] - beat_cyc[0], total - 1);
        end
        s_tvalid = 1'b0;
    endtask

    initial begin
        int n_done;

        reset    = 1'b1;
        abort    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        sel_b    = 1'b0;
        drive_start(1'b0);
        repeat (2) @(negedge clk);
        #1 check_reset_values("reset");
        reset = 1'b0;

        run_frame(0, 0, 0, 1'b0, "full_rate");
        run_frame(0, 1, 0, 1'b0, "ready_toggle");
        run_frame(1, 0, 0, 1'b0, "valid_gaps");
        run_frame(0, 0, 1, 1'b1, "start_while_busy");
        for (int r = 0; r < 3; r++) run_frame(2, 2, 1, 1'b0, "random");

        // Abort after two accepted samples
        @(negedge clk);
        drive_start(1'b1);
        s_tvalid = 1'b1;
        s_tdata  = 16'h0011;
        m_tready = 1'b1;
        @(negedge clk);
        drive_start(1'b0);
        #1 chk("abort.s_tready", o_s_tready, 1);
        @(negedge clk);
        s_tdata = 16'h0022;
        @(negedge clk);
        s_tvalid = 1'b0;
        abort    = 1'b1;
        #1 chk("abort.cnt_before", o_sample_cnt, 2);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort.m_tvalid", o_m_tvalid, 0);
        chk("abort.m_tlast", o_m_tlast, 0);
        chk("abort.busy", o_busy, 0);
        chk("abort.sample_cnt", o_sample_cnt, 2);
        chk("abort.s_tready", o_s_tready, 0);
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_done) n_done++;
            @(negedge clk);
            #1;
        end
        chk("abort.no_done", n_done, 0);

        // Reset while flushing
        @(negedge clk);
        drive_start(1'b1);
        s_tvalid = 1'b1;
        s_tdata  = 16'd1;
        m_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_start(1'b0);
            s_tdata = 16'(k + 1);
        end
        @(negedge clk);
        #1;
        chk("flush.s_tready", o_s_tready, 0);
        chk("flush.m_tdata", o_m_tdata, 4);
        chk("flush.busy", o_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        #1 check_reset_values("reset_mid_flush");
        reset    = 1'b0;
        s_tvalid = 1'b0;

        sel_b = 1'b1;
        run_frame(0, 0, 0, 1'b0, "ntaps1");
        run_frame(2, 2, 1, 1'b0, "ntaps1_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
